// File: rtl/mc_controller.sv
// Moore control FSM for the multi-cycle RV32I datapath.
// Every mux select and write enable decodes from the current state and the instruction fields.
module mc_controller #(
  parameter int unsigned STATE_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [6:0]         op,
  input  logic [2:0]         func3,
  input  logic [6:0]         func7,
  input  logic               zero,
  input  logic               alu_sign,
  output logic               pc_write,
  output logic               adr_src,
  output logic               ir_write,
  output logic               mem_write,
  output logic               reg_write,
  output logic [1:0]         result_src,
  output logic [1:0]         alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [2:0]         alu_control,
  output logic [2:0]         imm_src,
  output logic               illegal,
  output logic [STATE_W-1:0] state
);

  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpRType  = 7'b0110011;
  localparam logic [6:0] OpIType  = 7'b0010011;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpJalr   = 7'b1100111;
  localparam logic [6:0] OpLui    = 7'b0110111;

  localparam logic [2:0] AluAdd = 3'b000;
  localparam logic [2:0] AluSub = 3'b001;
  localparam logic [2:0] AluAnd = 3'b010;
  localparam logic [2:0] AluOr  = 3'b011;
  localparam logic [2:0] AluXor = 3'b100;
  localparam logic [2:0] AluSlt = 3'b101;

  localparam logic [2:0] ImmI = 3'b000;
  localparam logic [2:0] ImmS = 3'b001;
  localparam logic [2:0] ImmB = 3'b010;
  localparam logic [2:0] ImmJ = 3'b011;
  localparam logic [2:0] ImmU = 3'b100;

  typedef enum logic [STATE_W-1:0] {
    StFetch    = 'd0,
    StDecode   = 'd1,
    StMemAdr   = 'd2,
    StMemRead  = 'd3,
    StMemWb    = 'd4,
    StMemWrite = 'd5,
    StExecR    = 'd6,
    StExecI    = 'd7,
    StAluWb    = 'd8,
    StBranch   = 'd9,
    StJal      = 'd10,
    StJalr     = 'd11,
    StLink     = 'd12,
    StLui      = 'd13
  } state_e;

  state_e state_q, state_d;
  state_e out_st;

  logic unused_func7;
  assign unused_func7 = ^{func7[6], func7[4:0]};

  // Shared R/I-type ALU map; only R-type may turn func3 000 into a subtract.
  function automatic logic [2:0] alu_dec(input logic [2:0] f3, input logic sub_sel);
    logic [2:0] ctl;
    case (f3)
      3'b000:  ctl = sub_sel ? AluSub : AluAdd;
      3'b111:  ctl = AluAnd;
      3'b110:  ctl = AluOr;
      3'b100:  ctl = AluXor;
      3'b010:  ctl = AluSlt;
      default: ctl = AluAdd;
    endcase
    return ctl;
  endfunction

  logic op_known;
  logic br_taken;

  always_comb begin
    op_known = 1'b0;
    case (op)
      OpLoad, OpStore, OpRType, OpIType, OpBranch, OpJal, OpJalr, OpLui: op_known = 1'b1;
      default: op_known = 1'b0;
    endcase
  end

  always_comb begin
    br_taken = 1'b0;
    case (func3)
      3'b000:  br_taken = zero;
      3'b001:  br_taken = ~zero;
      3'b100:  br_taken = alu_sign;
      3'b101:  br_taken = ~alu_sign;
      default: br_taken = 1'b0;
    endcase
  end

  always_comb begin
    state_d = StFetch;
    case (state_q)
      StFetch:  state_d = StDecode;
      StDecode: begin
        case (op)
          OpLoad, OpStore: state_d = StMemAdr;
          OpRType:         state_d = StExecR;
          OpIType:         state_d = StExecI;
          OpBranch:        state_d = StBranch;
          OpJal:           state_d = StJal;
          OpJalr:          state_d = StJalr;
          OpLui:           state_d = StLui;
          default:         state_d = StFetch;
        endcase
      end
      StMemAdr:   state_d = (op == OpStore) ? StMemWrite : StMemRead;
      StMemRead:  state_d = StMemWb;
      StMemWb:    state_d = StFetch;
      StMemWrite: state_d = StFetch;
      StExecR:    state_d = StAluWb;
      StExecI:    state_d = StAluWb;
      StAluWb:    state_d = StFetch;
      StBranch:   state_d = StFetch;
      StJal:      state_d = StAluWb;
      StJalr:     state_d = StLink;
      StLink:     state_d = StAluWb;
      StLui:      state_d = StFetch;
      default:    state_d = StFetch;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StFetch;
    end else begin
      state_q <= state_d;
    end
  end

  assign state = state_q;

  // During reset the datapath sees FETCH selects with every write enable suppressed.
  assign out_st = rst ? StFetch : state_q;

  always_comb begin
    pc_write    = 1'b0;
    adr_src     = 1'b0;
    ir_write    = 1'b0;
    mem_write   = 1'b0;
    reg_write   = 1'b0;
    result_src  = 2'b00;
    alu_src_a   = 2'b00;
    alu_src_b   = 2'b00;
    alu_control = AluAdd;
    imm_src     = ImmI;
    illegal     = 1'b0;
    case (out_st)
      StFetch: begin
        ir_write   = 1'b1;
        pc_write   = 1'b1;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
      end
      StDecode: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
        imm_src   = (op == OpJal) ? ImmJ : ImmB;
        illegal   = ~op_known;
      end
      StMemAdr: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        imm_src   = (op == OpStore) ? ImmS : ImmI;
      end
      StMemRead: adr_src = 1'b1;
      StMemWb: begin
        result_src = 2'b01;
        reg_write  = 1'b1;
      end
      StMemWrite: begin
        adr_src   = 1'b1;
        mem_write = 1'b1;
      end
      StExecR: begin
        alu_src_a   = 2'b10;
        alu_control = alu_dec(func3, func7[5]);
      end
      StExecI: begin
        alu_src_a   = 2'b10;
        alu_src_b   = 2'b01;
        alu_control = alu_dec(func3, 1'b0);
      end
      StAluWb: reg_write = 1'b1;
      StBranch: begin
        alu_src_a   = 2'b10;
        alu_control = AluSub;
        pc_write    = br_taken;
      end
      StJal: begin
        pc_write  = 1'b1;
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
      end
      StJalr: begin
        alu_src_a  = 2'b10;
        alu_src_b  = 2'b01;
        result_src = 2'b10;
        pc_write   = 1'b1;
      end
      StLink: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
      end
      StLui: begin
        imm_src    = ImmU;
        result_src = 2'b11;
        reg_write  = 1'b1;
      end
      default: ;
    endcase
    if (rst) begin
      pc_write  = 1'b0;
      ir_write  = 1'b0;
      mem_write = 1'b0;
      reg_write = 1'b0;
      illegal   = 1'b0;
    end
  end

endmodule

// File: tb/tb_mc_controller.sv
// Scoreboard bench for mc_controller: stimulus queues per-cycle expected controls, a negedge
// monitor pops and compares them against the live outputs.
module tb_mc_controller;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] op;
  logic [2:0] func3;
  logic [6:0] func7;
  logic       zero, alu_sign;
  logic       pc_write, adr_src, ir_write, mem_write, reg_write, illegal;
  logic [1:0] result_src, alu_src_a, alu_src_b;
  logic [2:0] alu_control, imm_src;
  logic [3:0] state;

  int n_checks = 0;
  int n_fail   = 0;

  mc_controller #(.STATE_W(4)) dut (
    .clk(clk), .rst(rst), .op(op), .func3(func3), .func7(func7), .zero(zero),
    .alu_sign(alu_sign), .pc_write(pc_write), .adr_src(adr_src), .ir_write(ir_write),
    .mem_write(mem_write), .reg_write(reg_write), .result_src(result_src),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_control(alu_control),
    .imm_src(imm_src), .illegal(illegal), .state(state)
  );

  always #5 clk = ~clk;

  // Vector layout: {pc_write, adr_src, ir_write, mem_write, reg_write, illegal,
  //                 result_src, alu_src_a, alu_src_b, alu_control, imm_src}
  localparam logic [17:0] VFetch  = {6'b101000, 2'b10, 2'b00, 2'b10, 3'b000, 3'b000};
  localparam logic [17:0] VRst    = {6'b000000, 2'b10, 2'b00, 2'b10, 3'b000, 3'b000};
  localparam logic [17:0] VDecB   = {6'b000000, 2'b00, 2'b01, 2'b01, 3'b000, 3'b010};
  localparam logic [17:0] VDecJ   = {6'b000000, 2'b00, 2'b01, 2'b01, 3'b000, 3'b011};
  localparam logic [17:0] VDecIll = {6'b000001, 2'b00, 2'b01, 2'b01, 3'b000, 3'b010};
  localparam logic [17:0] VAdrLw  = {6'b000000, 2'b00, 2'b10, 2'b01, 3'b000, 3'b000};
  localparam logic [17:0] VAdrSw  = {6'b000000, 2'b00, 2'b10, 2'b01, 3'b000, 3'b001};
  localparam logic [17:0] VMemRd  = {6'b010000, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000};
  localparam logic [17:0] VMemWb  = {6'b000010, 2'b01, 2'b00, 2'b00, 3'b000, 3'b000};
  localparam logic [17:0] VMemWr  = {6'b010100, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000};
  localparam logic [17:0] VAluWb  = {6'b000010, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000};
  localparam logic [17:0] VBrT    = {6'b100000, 2'b00, 2'b10, 2'b00, 3'b001, 3'b000};
  localparam logic [17:0] VBrN    = {6'b000000, 2'b00, 2'b10, 2'b00, 3'b001, 3'b000};
  localparam logic [17:0] VJal    = {6'b100000, 2'b00, 2'b01, 2'b10, 3'b000, 3'b000};
  localparam logic [17:0] VJalr   = {6'b100000, 2'b10, 2'b10, 2'b01, 3'b000, 3'b000};
  localparam logic [17:0] VLink   = {6'b000000, 2'b00, 2'b01, 2'b10, 3'b000, 3'b000};
  localparam logic [17:0] VLui    = {6'b000010, 2'b11, 2'b00, 2'b00, 3'b000, 3'b100};

  typedef struct {
    string       name;
    logic [3:0]  st;
    logic [17:0] v;
  } exp_t;

  exp_t exp_q[$];

  task automatic expect_cyc(input string name, input logic [3:0] st, input logic [17:0] v);
    exp_t e;
    e.name = name;
    e.st   = st;
    e.v    = v;
    exp_q.push_back(e);
  endtask

  task automatic set_in(input logic [6:0] o, input logic [2:0] f3, input logic [6:0] f7,
                        input logic z, input logic s);
    op = o; func3 = f3; func7 = f7; zero = z; alu_sign = s;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      logic [17:0] act;
      e   = exp_q.pop_front();
      act = {pc_write, adr_src, ir_write, mem_write, reg_write, illegal,
             result_src, alu_src_a, alu_src_b, alu_control, imm_src};
      n_checks++;
      if (act !== e.v) begin
        n_fail++;
        $display("FAIL %s controls: got %b want %b", e.name, act, e.v);
      end
      n_checks++;
      if (state !== e.st) begin
        n_fail++;
        $display("FAIL %s state: got %0d want %0d", e.name, state, e.st);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    set_in(7'b0000011, 3'b010, 7'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    expect_cyc("rst_c1", 4'd0, VRst);
    expect_cyc("rst_c2", 4'd0, VRst);
    cycles(2);
    rst = 1'b0;

    // add, sub, and
    set_in(7'b0110011, 3'b000, 7'b0000000, 1'b0, 1'b0);
    expect_cyc("add_f", 4'd0, VFetch);
    expect_cyc("add_d", 4'd1, VDecB);
    expect_cyc("add_ex", 4'd6, {6'b0, 2'b00, 2'b10, 2'b00, 3'b000, 3'b000});
    expect_cyc("add_wb", 4'd8, VAluWb);
    cycles(4);
    set_in(7'b0110011, 3'b000, 7'b0100000, 1'b0, 1'b0);
    expect_cyc("sub_f", 4'd0, VFetch);
    expect_cyc("sub_d", 4'd1, VDecB);
    expect_cyc("sub_ex", 4'd6, {6'b0, 2'b00, 2'b10, 2'b00, 3'b001, 3'b000});
    expect_cyc("sub_wb", 4'd8, VAluWb);
    cycles(4);
    set_in(7'b0110011, 3'b111, 7'b0000000, 1'b0, 1'b0);
    expect_cyc("and_f", 4'd0, VFetch);
    expect_cyc("and_d", 4'd1, VDecB);
    expect_cyc("and_ex", 4'd6, {6'b0, 2'b00, 2'b10, 2'b00, 3'b010, 3'b000});
    expect_cyc("and_wb", 4'd8, VAluWb);
    cycles(4);

    // addi with func7[5] set must still add; ori
    set_in(7'b0010011, 3'b000, 7'b0100000, 1'b0, 1'b0);
    expect_cyc("addi_f", 4'd0, VFetch);
    expect_cyc("addi_d", 4'd1, VDecB);
    expect_cyc("addi_ex", 4'd7, {6'b0, 2'b00, 2'b10, 2'b01, 3'b000, 3'b000});
    expect_cyc("addi_wb", 4'd8, VAluWb);
    cycles(4);
    set_in(7'b0010011, 3'b110, 7'b0000000, 1'b0, 1'b0);
    expect_cyc("ori_f", 4'd0, VFetch);
    expect_cyc("ori_d", 4'd1, VDecB);
    expect_cyc("ori_ex", 4'd7, {6'b0, 2'b00, 2'b10, 2'b01, 3'b011, 3'b000});
    expect_cyc("ori_wb", 4'd8, VAluWb);
    cycles(4);

    // lw, sw
    set_in(7'b0000011, 3'b010, 7'b0, 1'b0, 1'b0);
    expect_cyc("lw_f", 4'd0, VFetch);
    expect_cyc("lw_d", 4'd1, VDecB);
    expect_cyc("lw_adr", 4'd2, VAdrLw);
    expect_cyc("lw_rd", 4'd3, VMemRd);
    expect_cyc("lw_wb", 4'd4, VMemWb);
    cycles(5);
    set_in(7'b0100011, 3'b010, 7'b0, 1'b0, 1'b0);
    expect_cyc("sw_f", 4'd0, VFetch);
    expect_cyc("sw_d", 4'd1, VDecB);
    expect_cyc("sw_adr", 4'd2, VAdrSw);
    expect_cyc("sw_wr", 4'd5, VMemWr);
    cycles(4);

    // branches
    set_in(7'b1100011, 3'b000, 7'b0, 1'b1, 1'b0);
    expect_cyc("beq_f", 4'd0, VFetch);
    expect_cyc("beq_d", 4'd1, VDecB);
    expect_cyc("beq_br", 4'd9, VBrT);
    cycles(3);
    set_in(7'b1100011, 3'b001, 7'b0, 1'b1, 1'b0);
    expect_cyc("bne_f", 4'd0, VFetch);
    expect_cyc("bne_d", 4'd1, VDecB);
    expect_cyc("bne_br", 4'd9, VBrN);
    cycles(3);
    set_in(7'b1100011, 3'b100, 7'b0, 1'b0, 1'b1);
    expect_cyc("blt_f", 4'd0, VFetch);
    expect_cyc("blt_d", 4'd1, VDecB);
    expect_cyc("blt_br", 4'd9, VBrT);
    cycles(3);
    set_in(7'b1100011, 3'b101, 7'b0, 1'b0, 1'b1);
    expect_cyc("bge_f", 4'd0, VFetch);
    expect_cyc("bge_d", 4'd1, VDecB);
    expect_cyc("bge_br", 4'd9, VBrN);
    cycles(3);

    // jal, jalr, lui
    set_in(7'b1101111, 3'b000, 7'b0, 1'b0, 1'b0);
    expect_cyc("jal_f", 4'd0, VFetch);
    expect_cyc("jal_d", 4'd1, VDecJ);
    expect_cyc("jal_j", 4'd10, VJal);
    expect_cyc("jal_wb", 4'd8, VAluWb);
    cycles(4);
    set_in(7'b1100111, 3'b000, 7'b0, 1'b0, 1'b0);
    expect_cyc("jalr_f", 4'd0, VFetch);
    expect_cyc("jalr_d", 4'd1, VDecB);
    expect_cyc("jalr_j", 4'd11, VJalr);
    expect_cyc("jalr_link", 4'd12, VLink);
    expect_cyc("jalr_wb", 4'd8, VAluWb);
    cycles(5);
    set_in(7'b0110111, 3'b000, 7'b0, 1'b0, 1'b0);
    expect_cyc("lui_f", 4'd0, VFetch);
    expect_cyc("lui_d", 4'd1, VDecB);
    expect_cyc("lui_x", 4'd13, VLui);
    cycles(3);

    // unsupported opcode
    set_in(7'b1111111, 3'b000, 7'b0, 1'b0, 1'b0);
    expect_cyc("ill_f", 4'd0, VFetch);
    expect_cyc("ill_d", 4'd1, VDecIll);
    cycles(2);

    // reset during MEMREAD abandons the load
    set_in(7'b0000011, 3'b010, 7'b0, 1'b0, 1'b0);
    expect_cyc("rlw_f", 4'd0, VFetch);
    expect_cyc("rlw_d", 4'd1, VDecB);
    expect_cyc("rlw_adr", 4'd2, VAdrLw);
    cycles(3);
    rst = 1'b1;
    expect_cyc("rlw_rst", 4'd3, VRst);
    cycles(1);
    rst = 1'b0;
    set_in(7'b0110111, 3'b000, 7'b0, 1'b0, 1'b0);
    expect_cyc("post_f", 4'd0, VFetch);
    expect_cyc("post_d", 4'd1, VDecB);
    expect_cyc("post_lui", 4'd13, VLui);
    cycles(3);

    cycles(2);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending entries want 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
